ack_bus_arbiter: RTL and testbench
==================================

Name: ack_bus_arbiter

Overview:
Shares the single completion-acknowledge bus between the command ports: memory (id 0), SHA (id 1), AES (id 2) and optionally one spare (id 3).
- Each port raises a request when its transaction finishes. The arbiter grants one port at a time, round-robin, and drives the bus id and valid for a fixed hold window.
- The owned flag returned to a port tells it its ack is on the bus; when owned falls, the port drops its request and returns to idle.

Parameters:
NUM_REQ, 3, number of requesters (1..4); requester index equals its 2-bit bus id
HOLD_CYCLES, 2, cycles the ack stays on the bus per grant (1..255)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
in_req  input  NUM_REQ  per-port ack request, level
out_owned  output  NUM_REQ  one-hot, high while that port's ack is on the bus
out_ack_valid  output  1  ack bus valid
out_ack_id  output  2  id of the port owning the bus; 0 when not valid
out_busy  output  1  high in GRANT or RELEASE

Behaviour:
- Reset (rst high at an edge): out_owned=0, out_ack_valid=0, out_ack_id=0, out_busy=0, state=IDLE, hold counter=0, served mask=0, round-robin pointer=0.
- Reset mid-grant aborts the grant; no partial-ack completion.
- Eligible[i] = in_req[i] AND NOT served[i].
- States:
  - IDLE: if any port is eligible at an edge, pick the first eligible index scanning from pointer upward, wrapping modulo NUM_REQ. Go to GRANT, register out_owned[g]=1, out_ack_valid=1, out_ack_id=g, load counter=HOLD_CYCLES-1. Otherwise stay.
  - GRANT: outputs held constant. At an edge with counter==0, go to RELEASE: clear out_owned, out_ack_valid and out_ack_id to 0; set served[g]=1; pointer=(g+1) mod NUM_REQ. Otherwise decrement counter.
  - RELEASE: one-cycle bus gap, then IDLE.
- Timing: request present before edge k gives outputs high from edge k for exactly HOLD_CYCLES cycles. Back-to-back grant period is HOLD_CYCLES+2 cycles.
- Served mask: served[i] clears at any edge where in_req[i]==0. A port that holds its request after owned falls is never re-granted until it deasserts for at least one edge.
- Clear has priority over set only for non-granted bits. Set at grant end wins for the granted bit.
- Request withdrawn during GRANT: the grant still runs to completion, because an ack is not retractable. Served is still set and clears on the next edge (req low).
- Simultaneous requests: only one grant at a time. The others wait in IDLE order; no request is lost while it stays asserted.
- The pointer only advances on grant completion. Starvation bound: a continuously eligible port is granted within NUM_REQ-1 other grants.
- Inputs at indices ≥ NUM_REQ do not exist; out_ack_id never exceeds NUM_REQ-1.
- out_busy = (state != IDLE), registered alongside the state.
- Counter is 8 bits; HOLD_CYCLES=1 gives a single-cycle valid.

Test Plan:
- Single request: rst for 2 cycles; in_req=3'b001 before edge 5, dropped after owned falls → owned[0], valid=1, id=0 from edge 5 for 2 cycles. Low from edge 7, busy low from edge 8. No second grant.
- Simultaneous: in_req=3'b111 held until each port's owned falls (each drops its own bit) → grants id0 at edge k, id1 at k+4, id2 at k+8. Each lasts 2 cycles with a 2-cycle gap. The owned one-hot never overlaps.
- Round-robin: after id1 is served (pointer=2), raise in_req=3'b011 together with a new 3'b100 → order is id2, id0, id1.
- Rearm: port 0 keeps in_req[0]=1 for 20 cycles after its grant → no regrant. Drop for 1 cycle, reassert → granted again at the first IDLE edge.
- Withdrawal: in_req[1] drops one cycle into its grant → valid stays high the full 2 cycles. id1 is not granted again unless reasserted.
- Reset mid-grant with HOLD_CYCLES=4: rst high on the 2nd grant cycle → all outputs 0 at that edge and pointer=0. With in_req=3'b110 afterwards, id1 is granted first.

Source files
------------

// File: rtl/ack_bus_arbiter.sv
// ack_bus_arbiter: round-robin owner of the shared completion-acknowledge bus
module ack_bus_arbiter #(
  parameter int NUM_REQ     = 3,
  parameter int HOLD_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] in_req,
  output logic [NUM_REQ-1:0] out_owned,
  output logic               out_ack_valid,
  output logic [1:0]         out_ack_id,
  output logic               out_busy
);
  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;
  state_t             state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [NUM_REQ-1:0] served_q, served_d, owned_q, owned_d, elig, pick_oh;
  logic [1:0]         ptr_q, ptr_d, id_q, id_d, pick, nxt;
  logic               valid_q, valid_d, busy_q, busy_d, found, grant, done;
  int                 d, best;
  assign elig = in_req & ~served_q;
  always_comb begin
    found = 1'b0;
    pick = 2'd0;
    best = 0;
    d = 0;
    pick_oh = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      d = (i >= int'(ptr_q)) ? i - int'(ptr_q) : i + NUM_REQ - int'(ptr_q);
      if (elig[i] && (!found || d < best)) begin
        found = 1'b1;
        best = d;
        pick = 2'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) pick_oh[i] = (pick == 2'(i));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      served_q <= '0;
      ptr_q    <= '0;
      owned_q  <= '0;
      valid_q  <= 1'b0;
      id_q     <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      served_q <= served_d;
      ptr_q    <= ptr_d;
      owned_q  <= owned_d;
      valid_q  <= valid_d;
      id_q     <= id_d;
      busy_q   <= busy_d;
    end
  end
  always_comb begin
    state_d = (state_q == IDLE)  ? (found ? GRANT : IDLE) :
              (state_q == GRANT) ? ((cnt_q == 8'd0) ? RELEASE : GRANT) : IDLE;
  end
  // A port still requesting after its ack stays masked until it drops once
  always_comb begin
    grant    = (state_q == IDLE) && found;
    done     = (state_q == GRANT) && (cnt_q == 8'd0);
    nxt      = (int'(id_q) == NUM_REQ - 1) ? 2'd0 : id_q + 2'd1;
    cnt_d    = grant ? 8'(HOLD_CYCLES - 1) : (state_q == GRANT && !done) ? cnt_q - 8'd1 : cnt_q;
    owned_d  = grant ? pick_oh : done ? '0 : owned_q;
    valid_d  = grant ? 1'b1 : done ? 1'b0 : valid_q;
    id_d     = grant ? pick : done ? 2'd0 : id_q;
    ptr_d    = done ? nxt : ptr_q;
    served_d = (served_q & in_req) | (done ? owned_q : '0);
    busy_d   = (state_d != IDLE);
  end
  assign out_owned     = owned_q;
  assign out_ack_valid = valid_q;
  assign out_ack_id    = id_q;
  assign out_busy      = busy_q;
endmodule

// File: tb/tb_ack_bus_arbiter.sv
// tb_ack_bus_arbiter: scoreboard bench for the ack bus arbiter
module tb_ack_bus_arbiter;
  localparam int H = 2;
  logic       clk = 1'b0;
  logic       rst_a, rst_b;
  logic [2:0] req_a, req_b, owned_a, owned_b, auto_m, prev_own;
  logic       valid_a, valid_b, busy_a, busy_b, pv;
  logic [1:0] id_a, id_b;
  int         checks = 0, failures = 0, cnt = 0;
  logic [1:0] q[$];
  logic [1:0] e;

  ack_bus_arbiter #(.NUM_REQ(3), .HOLD_CYCLES(2)) dut_a (
    .clk(clk), .rst(rst_a), .in_req(req_a), .out_owned(owned_a),
    .out_ack_valid(valid_a), .out_ack_id(id_a), .out_busy(busy_a));
  ack_bus_arbiter #(.NUM_REQ(3), .HOLD_CYCLES(4)) dut_b (
    .clk(clk), .rst(rst_b), .in_req(req_b), .out_owned(owned_b),
    .out_ack_valid(valid_b), .out_ack_id(id_b), .out_busy(busy_b));

  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  // Ports in auto mode drop their request once their owned flag falls
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++)
        if (auto_m[i] && prev_own[i] && !owned_a[i]) req_a[i] = 1'b0;
      prev_own = owned_a;
    end
  endtask

  task automatic reset_a;
    req_a = '0;
    auto_m = '0;
    rst_a = 1'b1;
    step(2);
    rst_a = 1'b0;
    step(1);
  endtask

  initial pv = 1'b0;
  always @(negedge clk) begin
    if (valid_a) begin
      if (!pv) begin
        cnt = 0;
        if (q.size() == 0) chk("unexpected_grant", int'(id_a), -1);
        else begin
          e = q.pop_front();
          chk("grant_id", int'(id_a), int'(e));
        end
      end
      cnt++;
      chk("owned_onehot", int'(owned_a), 1 << id_a);
    end else if (pv) begin
      chk("hold_len", cnt, H);
      chk("owned_clear", int'(owned_a), 0);
    end
    pv = valid_a;
  end

  initial begin
    prev_own = '0;
    req_b = '0;
    rst_b = 1'b1;
    reset_a();
    rst_b = 1'b0;
    chk("rst_owned", int'(owned_a), 0);
    chk("rst_valid", int'(valid_a), 0);
    chk("rst_id", int'(id_a), 0);
    chk("rst_busy", int'(busy_a), 0);
    chk("rst_b_valid", int'(valid_b), 0);
    // single request
    q.push_back(2'd0);
    req_a = 3'b001; auto_m = 3'b001;
    step(1);
    chk("s1_valid_first", int'(valid_a), 1);
    chk("s1_busy_first", int'(busy_a), 1);
    step(1);
    chk("s1_valid_second", int'(valid_a), 1);
    step(1);
    chk("s1_valid_low", int'(valid_a), 0);
    chk("s1_busy_release", int'(busy_a), 1);
    step(1);
    chk("s1_busy_low", int'(busy_a), 0);
    step(6);
    // simultaneous requests
    reset_a();
    q.push_back(2'd0); q.push_back(2'd1); q.push_back(2'd2);
    req_a = 3'b111; auto_m = 3'b111;
    step(14);
    chk("s2_busy_end", int'(busy_a), 0);
    // round-robin from pointer 2
    reset_a();
    q.push_back(2'd1);
    req_a = 3'b010; auto_m = 3'b111;
    step(6);
    q.push_back(2'd2); q.push_back(2'd0); q.push_back(2'd1);
    req_a = 3'b111;
    step(14);
    // rearm: held request is not regranted
    auto_m = '0;
    q.push_back(2'd0);
    req_a = 3'b001;
    step(22);
    chk("s4_no_regrant", int'(valid_a), 0);
    req_a = 3'b000;
    step(1);
    req_a = 3'b001; auto_m = 3'b001;
    q.push_back(2'd0);
    step(1);
    chk("s4_regrant_valid", int'(valid_a), 1);
    chk("s4_regrant_id", int'(id_a), 0);
    step(6);
    // withdrawal during grant
    auto_m = '0;
    q.push_back(2'd1);
    req_a = 3'b010;
    for (int i = 0; i < 10 && !valid_a; i++) step(1);
    chk("s5_grant_seen", int'(valid_a), 1);
    step(1);
    req_a = 3'b000;
    step(12);
    chk("s5_idle_valid", int'(valid_a), 0);
    chk("s5_idle_busy", int'(busy_a), 0);
    // reset mid-grant, HOLD_CYCLES=4
    req_b = 3'b010;
    step(1);
    chk("s6_g1_valid", int'(valid_b), 1);
    chk("s6_g1_id", int'(id_b), 1);
    req_b = 3'b000;
    step(8);
    req_b = 3'b001;
    step(1);
    chk("s6_g0_id", int'(id_b), 0);
    chk("s6_g0_owned", int'(owned_b), 1);
    rst_b = 1'b1;
    step(1);
    chk("s6_rst_owned", int'(owned_b), 0);
    chk("s6_rst_valid", int'(valid_b), 0);
    chk("s6_rst_id", int'(id_b), 0);
    chk("s6_rst_busy", int'(busy_b), 0);
    rst_b = 1'b0;
    req_b = 3'b110;
    step(1);
    chk("s6_after_valid", int'(valid_b), 1);
    chk("s6_after_id", int'(id_b), 1);
    chk("s6_after_owned", int'(owned_b), 2);
    step(3);
    chk("s6_hold4_high", int'(valid_b), 1);
    step(1);
    chk("s6_hold4_low", int'(valid_b), 0);
    chk("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
